// File: rtl/pipe_ctrl_pkg.sv
// Shared pipeline-control encodings for the 5-stage MIPS core.
// Hazard controller state values are fixed so debug tools can decode them.
package pipe_ctrl_pkg;

    localparam int NB_REG_DFLT = 5;

    typedef enum logic [1:0] {
        S_RUN     = 2'd0,
        S_LDSTALL = 2'd1,
        S_HALTED  = 2'd2
    } hz_state_t;

endpackage

// File: rtl/hazard_ctrl_unit.sv
// Pipeline hazard controller: load-use bubbles, memory-wait freeze, sticky halt,
// branch/jump flushes and a saturating stall-cycle counter for the debug unit.
module hazard_ctrl_unit
    import pipe_ctrl_pkg::*;
#(
    parameter int NB_REG          = NB_REG_DFLT,
    parameter int LOAD_USE_CYCLES = 1,
    parameter int NB_CNT          = 16
) (
    input  logic              i_clk,
    input  logic              i_reset,
    input  logic              i_branch_taken,
    input  logic              i_EX_jump,
    input  logic              i_MEM_jump,
    input  logic              i_WB_halt,
    input  logic              i_mem_ready,
    input  logic              i_ID_EX_mem_read,
    input  logic [NB_REG-1:0] i_ID_EX_rt,
    input  logic [NB_REG-1:0] i_IF_ID_rs,
    input  logic [NB_REG-1:0] i_IF_ID_rt,
    input  logic              i_IF_ID_uses_rt,
    output logic              o_enable_pc,
    output logic              o_enable_IF_ID,
    output logic              o_enable_ID_EX,
    output logic              o_flush_IF,
    output logic              o_flush_ID,
    output logic              o_flush_EX,
    output logic              o_halted,
    output logic [NB_CNT-1:0] o_stall_cycles
);

    if (LOAD_USE_CYCLES < 1 || LOAD_USE_CYCLES > 7) begin : g_bad_luc
        $error("hazard_ctrl_unit: LOAD_USE_CYCLES must be in 1..7");
    end

    localparam logic [2:0] LD_RELOAD = 3'(LOAD_USE_CYCLES - 1);

    hz_state_t         state_q, state_d;
    logic [2:0]        ld_cnt_q, ld_cnt_d;
    logic [NB_CNT-1:0] stall_q, stall_d;
    logic              ld_hit;

    // $zero never carries a real dependency; rt only matters if ID actually reads it
    assign ld_hit = i_ID_EX_mem_read && (i_ID_EX_rt != '0) &&
                    ((i_ID_EX_rt == i_IF_ID_rs) ||
                     (i_IF_ID_uses_rt && (i_ID_EX_rt == i_IF_ID_rt)));

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state_q  <= S_RUN;
            ld_cnt_q <= '0;
            stall_q  <= '0;
        end else begin
            state_q  <= state_d;
            ld_cnt_q <= ld_cnt_d;
            stall_q  <= stall_d;
        end
    end

    always_comb begin
        state_d        = state_q;
        ld_cnt_d       = ld_cnt_q;
        o_enable_pc    = 1'b1;
        o_enable_IF_ID = 1'b1;
        o_enable_ID_EX = 1'b1;
        o_flush_IF     = 1'b0;
        o_flush_ID     = 1'b0;
        o_flush_EX     = 1'b0;
        o_halted       = 1'b0;
        if (i_reset) begin
            state_d  = S_RUN;
            ld_cnt_d = '0;
        end else if (state_q == S_HALTED) begin
            o_enable_pc    = 1'b0;
            o_enable_IF_ID = 1'b0;
            o_enable_ID_EX = 1'b0;
            o_flush_IF     = 1'b1;
            o_flush_ID     = 1'b1;
            o_flush_EX     = 1'b1;
            o_halted       = 1'b1;
        end else if (!i_mem_ready) begin
            // freeze: nothing moves, state and bubble count hold
            o_enable_pc    = 1'b0;
            o_enable_IF_ID = 1'b0;
            o_enable_ID_EX = 1'b0;
        end else if (i_WB_halt) begin
            o_flush_IF = 1'b1;
            o_flush_ID = 1'b1;
            o_flush_EX = 1'b1;
            state_d    = S_HALTED;
            ld_cnt_d   = '0;
        end else if (i_branch_taken) begin
            o_flush_IF = 1'b1;
            o_flush_ID = 1'b1;
            o_flush_EX = 1'b1;
            state_d    = S_RUN;
            ld_cnt_d   = '0;
        end else if (i_EX_jump || i_MEM_jump) begin
            o_flush_ID = 1'b1;
            state_d    = S_RUN;
            ld_cnt_d   = '0;
        end else if (state_q == S_LDSTALL) begin
            o_enable_pc    = 1'b0;
            o_enable_IF_ID = 1'b0;
            o_flush_ID     = 1'b1;
            ld_cnt_d       = ld_cnt_q - 3'd1;
            if (ld_cnt_q == 3'd1) state_d = S_RUN;
        end else if (ld_hit) begin
            o_enable_pc    = 1'b0;
            o_enable_IF_ID = 1'b0;
            o_flush_ID     = 1'b1;
            if (LOAD_USE_CYCLES > 1) begin
                state_d  = S_LDSTALL;
                ld_cnt_d = LD_RELOAD;
            end
        end
    end

    always_comb begin
        stall_d = stall_q;
        if (!o_enable_pc && !(&stall_q)) stall_d = stall_q + 1'b1;
    end

    assign o_stall_cycles = stall_q;

endmodule
